// File: rtl/mem_stage.sv
// MIPS memory-access stage: byte-addressable little-endian data memory feeding
// the MEM/WB pipeline register, plus a combinational debug word read port.
module mem_stage #(
   parameter int BUS_SIZE       = 32,
   parameter int MEM_ADDR_WIDTH = 8
) (
   input  logic                      i_clk,
   input  logic                      i_reset,
   input  logic                      i_halt,
   input  logic [BUS_SIZE-1:0]       i_alu_result,
   input  logic [BUS_SIZE-1:0]       i_bus_b,
   input  logic [4:0]                i_wb_addr,
   input  logic                      i_reg_write,
   input  logic                      i_mem_read,
   input  logic                      i_mem_write,
   input  logic [1:0]                i_mem_size,
   input  logic                      i_mem_unsigned,
   input  logic [MEM_ADDR_WIDTH-1:0] i_dbg_addr,
   output logic [BUS_SIZE-1:0]       o_wb_data,
   output logic [4:0]                o_wb_addr,
   output logic                      o_reg_write,
   output logic                      o_misaligned,
   output logic [BUS_SIZE-1:0]       o_dbg_data
);

   localparam int DEPTH = 1 << MEM_ADDR_WIDTH;

   logic [BUS_SIZE-1:0]       mem_q [DEPTH];

   logic [MEM_ADDR_WIDTH-1:0] word_idx;
   logic [1:0]                lane;
   logic                      is_byte;
   logic                      is_half;
   logic                      misaligned;
   logic                      load;
   logic                      store_en;
   logic [3:0]                byte_en;
   logic [BUS_SIZE-1:0]       wr_data;
   logic [BUS_SIZE-1:0]       rd_word;
   logic [7:0]                rd_byte;
   logic [15:0]               rd_half;
   logic [BUS_SIZE-1:0]       load_val;

   logic [BUS_SIZE-1:0]       wb_data_q, wb_data_d;
   logic [4:0]                wb_addr_q, wb_addr_d;
   logic                      reg_write_q, reg_write_d;
   logic                      misaligned_q, misaligned_d;

   assign word_idx = i_alu_result[MEM_ADDR_WIDTH+1:2];
   assign lane     = i_alu_result[1:0];
   assign is_byte  = (i_mem_size == 2'b00);
   assign is_half  = (i_mem_size == 2'b01);

   assign misaligned = (is_half & lane[0]) |
                       (~is_byte & ~is_half & (lane != 2'b00));

   // A simultaneous read+write is an illegal encoding: the store wins.
   assign load     = i_mem_read & ~i_mem_write;
   assign store_en = i_mem_write & ~misaligned & ~i_halt;

   always_comb begin
      byte_en = 4'b1111;
      wr_data = i_bus_b;
      if (is_byte) begin
         byte_en = 4'b0001 << lane;
         wr_data = {(BUS_SIZE/8){i_bus_b[7:0]}};
      end else if (is_half) begin
         byte_en = lane[1] ? 4'b1100 : 4'b0011;
         wr_data = {(BUS_SIZE/16){i_bus_b[15:0]}};
      end
   end

   assign rd_word = mem_q[word_idx];
   assign rd_byte = rd_word[{lane, 3'b000} +: 8];
   assign rd_half = rd_word[{lane[1], 4'b0000} +: 16];

   always_comb begin
      load_val = rd_word;
      if (is_byte)
         load_val = {{(BUS_SIZE-8){~i_mem_unsigned & rd_byte[7]}}, rd_byte};
      else if (is_half)
         load_val = {{(BUS_SIZE-16){~i_mem_unsigned & rd_half[15]}}, rd_half};
   end

   always_comb begin
      wb_data_d    = i_alu_result;
      wb_addr_d    = i_wb_addr;
      reg_write_d  = i_reg_write & ~(i_mem_read & i_mem_write);
      misaligned_d = (i_mem_read | i_mem_write) & misaligned;
      if (load) begin
         wb_data_d = misaligned ? '0 : load_val;
         if (misaligned)
            reg_write_d = 1'b0;
      end
   end

   // Memory has no reset: contents survive a pipeline reset.
   always_ff @(posedge i_clk) begin
      if (store_en) begin
         for (int b = 0; b < 4; b++) begin
            if (byte_en[b])
               mem_q[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         wb_data_q    <= '0;
         wb_addr_q    <= '0;
         reg_write_q  <= 1'b0;
         misaligned_q <= 1'b0;
      end else if (!i_halt) begin
         wb_data_q    <= wb_data_d;
         wb_addr_q    <= wb_addr_d;
         reg_write_q  <= reg_write_d;
         misaligned_q <= misaligned_d;
      end
   end

   assign o_wb_data    = wb_data_q;
   assign o_wb_addr    = wb_addr_q;
   assign o_reg_write  = reg_write_q;
   assign o_misaligned = misaligned_q;
   assign o_dbg_data   = mem_q[i_dbg_addr];

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: byte-array reference model, per-cycle expected-output
// queue checked by an independent monitor, directed plan cases plus random ops.
module tb_mem_stage;

   typedef struct {
      logic [31:0] data;
      logic [4:0]  addr;
      logic        regw;
      logic        mis;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        halt;
   logic [31:0] alu, busb;
   logic [4:0]  wba;
   logic        regw, mrd, mwr, uns;
   logic [1:0]  msz;
   logic [7:0]  dbg_addr;
   logic [31:0] wb_data, dbg_data;
   logic [4:0]  wb_addr;
   logic        reg_write, misal;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] mm [1024];
   exp_t       cur;
   exp_t       exp_q [$];

   mem_stage #(.BUS_SIZE(32), .MEM_ADDR_WIDTH(8)) dut (
      .i_clk(clk), .i_reset(rst_n), .i_halt(halt),
      .i_alu_result(alu), .i_bus_b(busb), .i_wb_addr(wba),
      .i_reg_write(regw), .i_mem_read(mrd), .i_mem_write(mwr),
      .i_mem_size(msz), .i_mem_unsigned(uns), .i_dbg_addr(dbg_addr),
      .o_wb_data(wb_data), .o_wb_addr(wb_addr), .o_reg_write(reg_write),
      .o_misaligned(misal), .o_dbg_data(dbg_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
      end
   endtask

   function automatic logic [31:0] model_word(input int idx);
      return {mm[4*idx+3], mm[4*idx+2], mm[4*idx+1], mm[4*idx]};
   endfunction

   // Monitor: every edge out of reset has one expected output set queued.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("wb_data", wb_data, e.data);
            chk("wb_addr", {27'd0, wb_addr}, {27'd0, e.addr});
            chk("reg_write", {31'd0, reg_write}, {31'd0, e.regw});
            chk("misaligned", {31'd0, misal}, {31'd0, e.mis});
         end
      end
   end

   // Apply one instruction for one cycle, predict outputs, advance to next negedge.
   task automatic drive(input logic h, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] wa, input logic rw, input logic rd,
                        input logic wr, input logic [1:0] sz, input logic un);
      int    nb, base, off;
      logic  bad;
      logic [31:0] ld;
      dbg_addr = 8'($urandom);
      #1;
      chk("dbg_data", dbg_data, model_word(int'(dbg_addr)));
      halt = h; alu = a; busb = b; wba = wa; regw = rw;
      mrd = rd; mwr = wr; msz = sz; uns = un;
      nb   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
      base = int'(a[9:0]) & ~(nb - 1);
      bad  = (int'(a[9:0]) != base);
      if (!h) begin
         ld = 32'd0;
         for (int k = 0; k < nb; k++) ld = ld | (32'(mm[base+k]) << (8*k));
         if (!un && nb < 4 && ld[8*nb-1]) ld = ld | (32'hFFFF_FFFF << (8*nb));
         cur.data = (rd && !wr) ? (bad ? 32'd0 : ld) : a;
         cur.addr = wa;
         cur.regw = rw && !(rd && wr) && !(rd && !wr && bad);
         cur.mis  = (rd || wr) && bad;
         if (wr && !bad)
            for (int k = 0; k < nb; k++) mm[base+k] = b[8*k +: 8];
      end
      exp_q.push_back(cur);
      @(negedge clk);
   endtask

   task automatic nop(input logic [31:0] a, input logic [4:0] wa);
      drive(1'b0, a, 32'd0, wa, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0);
   endtask

   task automatic chk_dbg(input logic [7:0] idx, input logic [31:0] expv);
      dbg_addr = idx;
      #1;
      chk("dbg_word", dbg_data, expv);
   endtask

   initial begin
      logic [31:0] held;
      int r;
      rst_n = 1'b0; halt = 1'b0; alu = '0; busb = '0; wba = '0;
      regw = 1'b0; mrd = 1'b0; mwr = 1'b0; msz = 2'b10; uns = 1'b0; dbg_addr = '0;
      cur = '{data: 32'd0, addr: 5'd0, regw: 1'b0, mis: 1'b0};
      #12;
      chk("rst_wb_data", wb_data, 32'd0);
      chk("rst_wb_addr", {27'd0, wb_addr}, 32'd0);
      chk("rst_reg_write", {31'd0, reg_write}, 32'd0);
      chk("rst_misaligned", {31'd0, misal}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 256; i++)
         drive(1'b0, 32'(i*4), $urandom, 5'd0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0);

      // Store/load word
      drive(1'b0, 32'h10, 32'hDEADBEEF, 5'd0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0);
      drive(1'b0, 32'h10, 32'd0, 5'd5, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
      chk("lw_data", wb_data, 32'hDEADBEEF);
      chk("lw_addr", {27'd0, wb_addr}, 32'd5);
      chk("lw_regw", {31'd0, reg_write}, 32'd1);
      chk_dbg(8'd4, 32'hDEADBEEF);

      // Byte/halfword lanes and extension
      drive(1'b0, 32'h20, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0);
      drive(1'b0, 32'h22, 32'h80, 5'd0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
      chk_dbg(8'd8, 32'h0080_0000);
      drive(1'b0, 32'h22, 32'd0, 5'd3, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0);
      chk("lb", wb_data, 32'hFFFF_FF80);
      drive(1'b0, 32'h22, 32'd0, 5'd3, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1);
      chk("lbu", wb_data, 32'h0000_0080);
      drive(1'b0, 32'h20, 32'h8001, 5'd0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0);
      chk_dbg(8'd8, 32'h0080_8001);
      drive(1'b0, 32'h20, 32'd0, 5'd3, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0);
      chk("lh", wb_data, 32'hFFFF_8001);

      // Misaligned
      drive(1'b0, 32'h21, 32'h1111_1111, 5'd0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0);
      chk("sw_mis_flag", {31'd0, misal}, 32'd1);
      chk_dbg(8'd8, 32'h0080_8001);
      drive(1'b0, 32'h23, 32'd0, 5'd9, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0);
      chk("lh_mis_regw", {31'd0, reg_write}, 32'd0);
      chk("lh_mis_data", wb_data, 32'd0);
      chk("lh_mis_flag", {31'd0, misal}, 32'd1);

      // Passthrough and address wrap
      nop(32'h1234, 5'd7);
      chk("pass_data", wb_data, 32'h1234);
      chk("pass_addr", {27'd0, wb_addr}, 32'd7);
      chk("pass_mis", {31'd0, misal}, 32'd0);
      drive(1'b0, 32'h400, 32'hA5A5A5A5, 5'd0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0);
      drive(1'b0, 32'h0, 32'd0, 5'd2, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
      chk("wrap_lw", wb_data, 32'hA5A5A5A5);

      // Halt
      held = model_word(12);
      for (int i = 0; i < 3; i++)
         drive(1'b1, 32'h30, $urandom, 5'(i + 20), 1'b1, 1'b0, 1'b1, 2'b10, 1'b0);
      chk("halt_data", wb_data, 32'hA5A5A5A5);
      chk("halt_addr", {27'd0, wb_addr}, 32'd2);
      chk_dbg(8'd12, held);
      nop(32'h55, 5'd11);
      chk("unhalt_data", wb_data, 32'h55);

      // Random traffic
      for (int i = 0; i < 1500; i++) begin
         logic [31:0] a;
         r = $urandom_range(0, 7);
         a = $urandom;
         if ($urandom_range(0, 3) != 0) a = a & 32'h0000_007F;
         drive($urandom_range(0, 9) == 0, a, $urandom, 5'($urandom), 1'($urandom),
               (r <= 2) || (r == 5), (r == 3) || (r == 4) || (r == 5),
               2'($urandom), 1'($urandom));
      end

      // Asynchronous reset between edges
      drive(1'b0, 32'h44, 32'h0BAD_F00D, 5'd0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0);
      nop(32'hFFFF_FFFF, 5'd31);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_wb_data", wb_data, 32'd0);
      chk("arst_wb_addr", {27'd0, wb_addr}, 32'd0);
      chk("arst_reg_write", {31'd0, reg_write}, 32'd0);
      chk("arst_misaligned", {31'd0, misal}, 32'd0);
      cur = '{data: 32'd0, addr: 5'd0, regw: 1'b0, mis: 1'b0};
      @(negedge clk);
      rst_n = 1'b1;
      chk_dbg(8'd17, 32'h0BAD_F00D);
      nop(32'h77, 5'd1);
      chk("post_rst_data", wb_data, 32'h77);

      @(negedge clk);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
